// File: rtl/tf_512to8_pkg.sv
//------------------------------------------------------------------------------
// Module      : tf_512to8_pkg
// Description : Shared widths, header encodings and word layout for the
//               512-to-8 transmit converter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tf_512to8_pkg;

  localparam int WORD_W      = 520;
  localparam int META_W      = 112;
  localparam int DATA_W      = 512;
  localparam int LEN_W       = 11;
  localparam int META_LEN_HI = 106;
  localparam int META_LEN_LO = 96;

  localparam logic [1:0] HDR_HEAD   = 2'b10;
  localparam logic [1:0] HDR_MID    = 2'b00;
  localparam logic [1:0] HDR_TAIL   = 2'b01;
  localparam logic [1:0] HDR_SINGLE = 2'b11;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef struct packed {
    logic [1:0]        hdr;
    logic [5:0]        invalid;
    logic [DATA_W-1:0] data;
  } tf_word_t;

  // Head and single words start a packet.
  function automatic logic hdr_is_head(input logic [1:0] h);
    return (h == HDR_HEAD) || (h == HDR_SINGLE);
  endfunction

  // Tail and single words end a packet.
  function automatic logic hdr_is_tail(input logic [1:0] h);
    return (h == HDR_TAIL) || (h == HDR_SINGLE);
  endfunction

  // Head and middle words leave a packet open behind them.
  function automatic logic hdr_leaves_open(input logic [1:0] h);
    return (h == HDR_HEAD) || (h == HDR_MID);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tf_sync_fifo.sv
//------------------------------------------------------------------------------
// Module      : tf_sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy count. Writes while
//               full and reads while empty are ignored.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous write and read keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tf_512to8.sv
//------------------------------------------------------------------------------
// Module      : tf_512to8
// Description : Serializes 512-bit packet words MSB-byte-first onto an 8-bit
//               AXI-Stream transmit port, checking headers and lengths.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tf_512to8
  import tf_512to8_pkg::*;
#(
  parameter int WORD_FIFO_DEPTH = 16,
  parameter int META_FIFO_DEPTH = 8,
  parameter int ALF_MARGIN      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] TF_512to8_in,
  input  logic              TF_512to8_in_wr,
  input  logic [META_W-1:0] TF_512to8_in_valid,
  input  logic              TF_512to8_in_valid_wr,
  output logic              TF_512to8_out_alf,
  output logic [7:0]        s_axis_tx_tdata,
  output logic              s_axis_tx_tvalid,
  output logic              s_axis_tx_tlast,
  input  logic              s_axis_tx_tready,
  output logic [15:0]       pkt_out_cnt,
  output logic [15:0]       err_cnt
);

  localparam int WCW = $clog2(WORD_FIFO_DEPTH) + 1;
  localparam int MCW = $clog2(META_FIFO_DEPTH) + 1;
  localparam logic [WCW-1:0] ALF_LEVEL = WCW'(WORD_FIFO_DEPTH - ALF_MARGIN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [WORD_W-1:0] word_dout;
  tf_word_t          head_word;
  logic              word_empty;
  logic              word_full;
  logic [WCW-1:0]    word_count;
  logic              word_pop;

  logic [LEN_W-1:0]  meta_dout;
  logic              meta_empty;
  logic              meta_full;
  logic [MCW-1:0]    meta_count_unused;
  logic              meta_bits_unused;

  logic [0:0]        state;
  logic [DATA_W-1:0] word_reg;
  logic              tail_reg;
  logic [5:0]        byte_idx;
  logic [5:0]        last_idx;
  logic              open_pkt;
  logic [LEN_W-1:0]  len_acc;

  logic              hs;
  logic              tail_hs;
  logic              load_out;
  logic              at_last;
  logic [7:0]        byte_sel;
  logic [LEN_W-1:0]  len_next;
  logic              hdr_err;
  logic              tail_err;
  logic              drop_err;

  assign meta_bits_unused = ^{TF_512to8_in_valid[META_W-1:META_LEN_HI+1],
                              TF_512to8_in_valid[META_LEN_LO-1:0]};

  tf_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (WORD_FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (TF_512to8_in_wr),
    .din   (TF_512to8_in),
    .rd    (word_pop),
    .dout  (word_dout),
    .empty (word_empty),
    .full  (word_full),
    .count (word_count)
  );

  tf_sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (META_FIFO_DEPTH)
  ) u_meta_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (TF_512to8_in_valid_wr),
    .din   (TF_512to8_in_valid[META_LEN_HI:META_LEN_LO]),
    .rd    (tail_hs),
    .dout  (meta_dout),
    .empty (meta_empty),
    .full  (meta_full),
    .count (meta_count_unused)
  );

  assign head_word = tf_word_t'(word_dout);

  // The output register refills whenever it is empty or being accepted, so
  // tdata/tvalid/tlast stay frozen during a stall.
  assign hs       = s_axis_tx_tvalid && s_axis_tx_tready;
  assign tail_hs  = hs && s_axis_tx_tlast;
  assign load_out = (state == ST_SEND) && (!s_axis_tx_tvalid || s_axis_tx_tready);
  assign at_last  = (byte_idx == last_idx);
  assign word_pop = !word_empty && ((state == ST_IDLE) || (load_out && at_last));

  // Byte k of the word sits at bits [511-8k -: 8]; 511-8k == {~k, 3'b111}.
  assign byte_sel = word_reg[{~byte_idx, 3'b111} -: 8];

  assign len_next = (len_acc == LEN_MAX) ? len_acc : len_acc + 11'd1;
  assign hdr_err  = word_pop && (hdr_is_head(head_word.hdr) ? open_pkt : !open_pkt);
  assign tail_err = tail_hs && (meta_empty || (meta_dout != len_next));
  assign drop_err = (TF_512to8_in_wr && word_full) ||
                    (TF_512to8_in_valid_wr && meta_full);

  // Word loader and byte walker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_reg <= '0;
      tail_reg <= 1'b0;
      byte_idx <= '0;
      last_idx <= '0;
      open_pkt <= 1'b0;
    end else begin
      if (word_pop) begin
        state    <= ST_SEND;
        word_reg <= head_word.data;
        tail_reg <= hdr_is_tail(head_word.hdr);
        byte_idx <= '0;
        last_idx <= hdr_is_tail(head_word.hdr) ? 6'd63 - head_word.invalid : 6'd63;
        open_pkt <= hdr_leaves_open(head_word.hdr);
      end else if (load_out) begin
        byte_idx <= byte_idx + 6'd1;
        if (at_last) state <= ST_IDLE;
      end
    end
  end

  // Registered AXI-Stream output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tx_tdata  <= '0;
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tlast  <= 1'b0;
    end else if (load_out) begin
      s_axis_tx_tdata  <= byte_sel;
      s_axis_tx_tvalid <= 1'b1;
      s_axis_tx_tlast  <= tail_reg && at_last;
    end else if (hs) begin
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tlast  <= 1'b0;
    end
  end

  // Length accounting, packet/error counters and almost-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_acc           <= '0;
      pkt_out_cnt       <= '0;
      err_cnt           <= '0;
      TF_512to8_out_alf <= 1'b0;
    end else begin
      if (tail_hs)  len_acc <= '0;
      else if (hs)  len_acc <= len_next;
      if (tail_hs) pkt_out_cnt <= pkt_out_cnt + 16'd1;
      if (hdr_err || tail_err || drop_err) err_cnt <= err_cnt + 16'd1;
      TF_512to8_out_alf <= (word_count >= ALF_LEVEL);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tf_512to8.sv
//------------------------------------------------------------------------------
// Module      : tb_tf_512to8
// Description : Directed self-checking bench for tf_512to8.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tf_512to8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [519:0] in_word;
  logic         in_wr;
  logic [111:0] in_meta;
  logic         in_meta_wr;
  logic         alf;
  logic [7:0]   tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic [15:0]  pkt_cnt;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wcyc   = 0;
  int hold_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [7:0] q_data [$];
  logic       q_last [$];
  int         q_cyc  [$];

  tf_512to8 dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .TF_512to8_in          (in_word),
    .TF_512to8_in_wr       (in_wr),
    .TF_512to8_in_valid    (in_meta),
    .TF_512to8_in_valid_wr (in_meta_wr),
    .TF_512to8_out_alf     (alf),
    .s_axis_tx_tdata       (tdata),
    .s_axis_tx_tvalid      (tvalid),
    .s_axis_tx_tlast       (tlast),
    .s_axis_tx_tready      (tready),
    .pkt_out_cnt           (pkt_cnt),
    .err_cnt               (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted byte and watch that stalled outputs stay frozen.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
      q_cyc.push_back(cyc);
    end
    if (rst_n && prev_stall && (!tvalid || tdata !== prev_data)) hold_bad <= hold_bad + 1;
    prev_stall <= rst_n && tvalid && !tready;
    prev_data  <= tdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_data(input logic [7:0] s);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 64; k++) d[511-8*k -: 8] = s + 8'(k);
    return d;
  endfunction

  task automatic write_word(input logic [1:0] hdr, input logic [5:0] inv, input logic [7:0] seed);
    in_word = {hdr, inv, mk_data(seed)};
    in_wr   = 1'b1;
    step();
    wcyc    = cyc;
    in_wr   = 1'b0;
  endtask

  // Unused metadata bits are set to ones to show they are ignored.
  task automatic write_meta(input logic [10:0] len);
    in_meta    = {5'h1F, len, {96{1'b1}}};
    in_meta_wr = 1'b1;
    step();
    in_meta_wr = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) step();
    check(tag, 32'(q_data.size() >= n), 32'd1);
  endtask

  // Bytes [start, start+n) of the capture must be seed, seed+1, ...
  task automatic check_bytes(input string tag, input int start, input logic [7:0] seed, input int n);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      e = seed + 8'(k);
      if (start + k >= q_data.size()) bad++;
      else if (q_data[start+k] !== e) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Exactly n bytes captured with a single tlast on the final one.
  task automatic check_pkt(input string tag, input int n);
    int lasts;
    lasts = 0;
    foreach (q_last[i]) if (q_last[i]) lasts++;
    check({tag, "_count"}, 32'(q_data.size()), 32'(n));
    check({tag, "_tlast_count"}, 32'(lasts), 32'd1);
    if (q_last.size() == n) check({tag, "_tlast_pos"}, 32'(q_last[n-1]), 32'd1);
  endtask

  initial begin
    int hb;
    rst_n      = 1'b0;
    tready     = 1'b0;
    in_word    = '0;
    in_wr      = 1'b0;
    in_meta    = '0;
    in_meta_wr = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_alf", 32'(alf), 32'd0);
    check("rst_pkt", 32'(pkt_cnt), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Single-word packet, 4 valid bytes
    tready = 1'b1;
    clear_q();
    write_meta(11'd4);
    write_word(2'b11, 6'd60, 8'h10);
    wait_bytes("t1_timeout", 4, 100);
    repeat (5) step();
    check_pkt("t1", 4);
    check_bytes("t1_bytes", 0, 8'h10, 4);
    if (q_cyc.size() > 0) check("t1_latency", 32'(q_cyc[0] - wcyc), 32'd2);
    check("t1_pkt", 32'(pkt_cnt), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Three-word 130-byte packet with no bubbles
    clear_q();
    write_meta(11'd130);
    write_word(2'b10, 6'd0, 8'h20);
    write_word(2'b00, 6'd0, 8'h60);
    write_word(2'b01, 6'd62, 8'hA0);
    wait_bytes("t2_timeout", 130, 400);
    repeat (5) step();
    check_pkt("t2", 130);
    check_bytes("t2_head", 0, 8'h20, 64);
    check_bytes("t2_mid", 64, 8'h60, 64);
    check_bytes("t2_tail", 128, 8'hA0, 2);
    if (q_cyc.size() == 130) check("t2_no_bubble", 32'(q_cyc[129] - q_cyc[0]), 32'd129);
    check("t2_pkt", 32'(pkt_cnt), 32'd2);
    check("t2_err", 32'(err_cnt), 32'd0);

    // 64-byte word with tready toggling every cycle
    clear_q();
    tready = 1'b0;
    hb = hold_bad;
    write_meta(11'd64);
    write_word(2'b11, 6'd0, 8'h80);
    for (int i = 0; i < 50 && !tvalid; i++) step();
    check("t3_valid", 32'(tvalid), 32'd1);
    for (int i = 0; i < 64; i++) begin
      tready = 1'b1;
      step();
      tready = 1'b0;
      step();
    end
    tready = 1'b1;
    repeat (5) step();
    check_pkt("t3", 64);
    check_bytes("t3_bytes", 0, 8'h80, 64);
    if (q_cyc.size() == 64) check("t3_span", 32'(q_cyc[63] - q_cyc[0]), 32'd126);
    check("t3_hold", 32'(hold_bad - hb), 32'd0);
    check("t3_pkt", 32'(pkt_cnt), 32'd3);
    check("t3_err", 32'(err_cnt), 32'd0);

    // Length mismatch: metadata says 100, word carries 64
    clear_q();
    write_meta(11'd100);
    write_word(2'b11, 6'd0, 8'hC3);
    wait_bytes("t4_timeout", 64, 200);
    repeat (5) step();
    check_pkt("t4", 64);
    check_bytes("t4_bytes", 0, 8'hC3, 64);
    check("t4_pkt", 32'(pkt_cnt), 32'd4);
    check("t4_err", 32'(err_cnt), 32'd1);

    // Fill the word FIFO behind a stalled word until it overflows
    tready = 1'b0;
    write_word(2'b11, 6'd0, 8'h33);
    for (int i = 0; i < 20 && !tvalid; i++) step();
    check("t5_preload", 32'(tvalid), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      write_word(2'b11, 6'd0, 8'(k));
      if (k == 12) check("t5_alf_lag", 32'(alf), 32'd0);
      if (k == 13) check("t5_alf_set", 32'(alf), 32'd1);
      if (k == 16) check("t5_err_before_drop", 32'(err_cnt), 32'd1);
      if (k == 17) check("t5_err_drop", 32'(err_cnt), 32'd2);
      if (k == 17) check("t5_alf_full", 32'(alf), 32'd1);
    end
    rst_n = 1'b0;
    step();
    check("t5_rst_tvalid", 32'(tvalid), 32'd0);
    check("t5_rst_pkt", 32'(pkt_cnt), 32'd0);
    check("t5_rst_err", 32'(err_cnt), 32'd0);
    check("t5_rst_alf", 32'(alf), 32'd0);
    clear_q();
    rst_n  = 1'b1;
    tready = 1'b1;
    repeat (5) step();
    check("t5_fifo_empty", 32'(q_data.size()), 32'd0);

    // Reset in the middle of a packet, then a fresh packet
    clear_q();
    write_meta(11'd64);
    write_word(2'b11, 6'd0, 8'h50);
    wait_bytes("t6_timeout", 20, 100);
    begin
      int lasts;
      lasts = 0;
      foreach (q_last[i]) if (q_last[i]) lasts++;
      check("t6_partial_no_tlast", 32'(lasts), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", 32'(tvalid), 32'd0);
    check("t6_async_tdata", 32'(tdata), 32'd0);
    step();
    check("t6_rst_tlast", 32'(tlast), 32'd0);
    check("t6_rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    clear_q();
    write_meta(11'd8);
    write_word(2'b11, 6'd56, 8'hE0);
    wait_bytes("t6b_timeout", 8, 100);
    repeat (5) step();
    check_pkt("t6b", 8);
    check_bytes("t6b_bytes", 0, 8'hE0, 8);
    check("t6b_pkt", 32'(pkt_cnt), 32'd1);
    check("t6b_err", 32'(err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
